// File: rtl/ex_mem_pkg.sv
// Shared types and default widths for the EX/MEM pipeline stage.
package ex_mem_pkg;

   localparam int EX_MEM_DATA_W = 32;
   localparam int EX_MEM_CTRL_W = 4;

   // Encoding chosen so bit 0 is the main valid bit and bit 1 the skid valid bit.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      BUSY  = 2'b01,
      FULL  = 2'b11
   } stage_state_e;

   function automatic logic main_valid_of(input stage_state_e s);
      return s[0];
   endfunction

   function automatic logic skid_valid_of(input stage_state_e s);
      return s[1];
   endfunction

endpackage

// File: rtl/ex_mem_if.sv
// Valid/ready handshake bundle carrying a payload and control bits.
// The producer side uses the master modport, the consumer side the slave modport.
interface ex_mem_if
   import ex_mem_pkg::*;
#(
   parameter int DATA_W = EX_MEM_DATA_W,
   parameter int CTRL_W = EX_MEM_CTRL_W
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] control;

   modport master (
      output valid,
      output data,
      output control,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  control,
      output ready
   );
endinterface

// File: rtl/ex_mem_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module ex_mem_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   // Count up on inc until every bit is set, then hold.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: 2-entry elastic skid buffer between execute and memory.
// Optional stall counter enabled by defining EX_MEM_PERF_EN.
//
// state | meaning
// EMPTY | no entry held; mem_valid=0, ex_ready=1
// BUSY  | main holds the head entry; skid empty, ex_ready=1
// FULL  | main and skid both hold entries; ex_ready=0
module ex_mem_stage
   import ex_mem_pkg::*;
#(
   parameter int DATA_W = EX_MEM_DATA_W,
   parameter int CTRL_W = EX_MEM_CTRL_W
`ifdef EX_MEM_PERF_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      flush,
   ex_mem_if.slave   ex,
   ex_mem_if.master  mem
`ifdef EX_MEM_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   stage_state_e      state;
   stage_state_e      state_nxt;
   logic              main_valid;
   logic              skid_valid;
   logic              up_xfer;
   logic              dn_xfer;
   logic              load_main_ex;
   logic              load_main_skid;
   logic              load_skid;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;

   // Valid bits are state bits, so ex_ready and mem_valid come straight from flops
   // and ex_ready never sees mem_ready combinationally.
   assign main_valid = main_valid_of(state);
   assign skid_valid = skid_valid_of(state);

   assign ex.ready    = ~skid_valid;
   assign mem.valid   = main_valid;
   assign mem.data    = main_data;
   // Bubbles present as NOP control.
   assign mem.control = main_ctrl & {CTRL_W{main_valid}};

   assign up_xfer = ex.valid & ~skid_valid;
   assign dn_xfer = main_valid & mem.ready;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and register load selects; flush overrides every transfer.
   always_comb begin
      state_nxt      = state;
      load_main_ex   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (up_xfer) begin
                  state_nxt    = BUSY;
                  load_main_ex = 1'b1;
               end
            end
            BUSY: begin
               if (up_xfer && dn_xfer) begin
                  load_main_ex = 1'b1;
               end else if (dn_xfer) begin
                  state_nxt = EMPTY;
               end else if (up_xfer) begin
                  state_nxt = FULL;
                  load_skid = 1'b1;
               end
            end
            FULL: begin
               if (dn_xfer) begin
                  state_nxt      = BUSY;
                  load_main_skid = 1'b1;
               end
            end
            default: begin
               state_nxt = EMPTY;
            end
         endcase
      end
   end

   // Payload registers hold unless loaded; visibility is governed by the valid bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         main_data <= '0;
         main_ctrl <= '0;
         skid_data <= '0;
         skid_ctrl <= '0;
      end else begin
         if (load_main_ex) begin
            main_data <= ex.data;
            main_ctrl <= ex.control;
         end else if (load_main_skid) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
         end
         if (load_skid) begin
            skid_data <= ex.data;
            skid_ctrl <= ex.control;
         end
      end
   end

`ifdef EX_MEM_PERF_EN
   // Stall cycles: head valid but downstream not accepting. Flush does not clear.
   ex_mem_sat_cnt #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (main_valid & ~mem.ready),
      .count (stall_cnt)
   );
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage.
module tb_ex_mem_stage;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   int   total = 0;
   int   bad   = 0;

   ex_mem_if #(.DATA_W(32), .CTRL_W(4)) ex_bus ();
   ex_mem_if #(.DATA_W(32), .CTRL_W(4)) mem_bus ();

`ifdef EX_MEM_PERF_EN
   logic [3:0] stall_cnt;
   ex_mem_stage #(.DATA_W(32), .CTRL_W(4), .CNT_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .ex        (ex_bus),
      .mem       (mem_bus),
      .stall_cnt (stall_cnt)
   );
`else
   ex_mem_stage #(.DATA_W(32), .CTRL_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .ex    (ex_bus),
      .mem   (mem_bus)
   );
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic        ev;
      logic [31:0] ed;
      logic [3:0]  ec;
      logic        mr;
      logic        fl;
      logic        xmv;
      logic [31:0] xmd;
      logic [3:0]  xmc;
      logic        xer;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ev, input logic [31:0] ed, input logic [3:0] ec,
                        input logic mr, input logic fl);
      ex_bus.valid   = ev;
      ex_bus.data    = ed;
      ex_bus.control = ec;
      mem_bus.ready  = mr;
      flush          = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic mv, input logic [31:0] md,
                          input logic [3:0] mc, input logic er);
      chk({tag, ".mem_valid"},   {31'd0, mem_bus.valid}, {31'd0, mv});
      chk({tag, ".mem_data"},    mem_bus.data, md);
      chk({tag, ".mem_control"}, {28'd0, mem_bus.control}, {28'd0, mc});
      chk({tag, ".ex_ready"},    {31'd0, ex_bus.ready}, {31'd0, er});
   endtask

   initial begin
      //            ev    data           ec    mr    fl    mv    mem_data       mc    er
      // streaming
      vecs[0]  = '{1'b1, 32'hA5A5A5A5, 4'h1, 1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 4'h1, 1'b1};
      vecs[1]  = '{1'b1, 32'h5A5A5A5A, 4'h0, 1'b1, 1'b0, 1'b1, 32'h5A5A5A5A, 4'h0, 1'b1};
      vecs[2]  = '{1'b0, 32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0, 32'h5A5A5A5A, 4'h0, 1'b1};
      // backpressure, then drain in order
      vecs[3]  = '{1'b1, 32'h11111111, 4'h2, 1'b0, 1'b0, 1'b1, 32'h11111111, 4'h2, 1'b1};
      vecs[4]  = '{1'b1, 32'h22222222, 4'h3, 1'b0, 1'b0, 1'b1, 32'h11111111, 4'h2, 1'b0};
      vecs[5]  = '{1'b1, 32'h33333333, 4'h4, 1'b0, 1'b0, 1'b1, 32'h11111111, 4'h2, 1'b0};
      vecs[6]  = '{1'b1, 32'h33333333, 4'h4, 1'b1, 1'b0, 1'b1, 32'h22222222, 4'h3, 1'b1};
      vecs[7]  = '{1'b1, 32'h33333333, 4'h4, 1'b1, 1'b0, 1'b1, 32'h33333333, 4'h4, 1'b1};
      vecs[8]  = '{1'b0, 32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0, 32'h33333333, 4'h0, 1'b1};
      // flush in FULL with an upstream entry offered
      vecs[9]  = '{1'b1, 32'h66666666, 4'h5, 1'b0, 1'b0, 1'b1, 32'h66666666, 4'h5, 1'b1};
      vecs[10] = '{1'b1, 32'h77777777, 4'h6, 1'b0, 1'b0, 1'b1, 32'h66666666, 4'h5, 1'b0};
      vecs[11] = '{1'b1, 32'h44444444, 4'h7, 1'b0, 1'b1, 1'b0, 32'h66666666, 4'h0, 1'b1};
      vecs[12] = '{1'b0, 32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0, 32'h66666666, 4'h0, 1'b1};
      // flush in BUSY while an upstream transfer would otherwise happen
      vecs[13] = '{1'b1, 32'h88888888, 4'h8, 1'b0, 1'b0, 1'b1, 32'h88888888, 4'h8, 1'b1};
      vecs[14] = '{1'b1, 32'h99999999, 4'h9, 1'b1, 1'b1, 1'b0, 32'h88888888, 4'h0, 1'b1};
      vecs[15] = '{1'b0, 32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0, 32'h88888888, 4'h0, 1'b1};

      drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      reset = 1'b1;
      step();
      step();
      chk_out("reset", 1'b0, 32'h0, 4'h0, 1'b1);
`ifdef EX_MEM_PERF_EN
      chk("reset.stall_cnt", {28'd0, stall_cnt}, 32'd0);
`endif

      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].ev, vecs[i].ed, vecs[i].ec, vecs[i].mr, vecs[i].fl);
         step();
         chk_out($sformatf("vec%0d", i), vecs[i].xmv, vecs[i].xmd, vecs[i].xmc, vecs[i].xer);
         @(negedge clk);
      end

      // Reset in the middle of a stall clears both entries and the payload.
      drive(1'b1, 32'hCAFEF00D, 4'hA, 1'b0, 1'b0);
      step();
      @(negedge clk);
      drive(1'b1, 32'hDEADBEEF, 4'hB, 1'b0, 1'b0);
      step();
      chk_out("midfill", 1'b1, 32'hCAFEF00D, 4'hA, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      step();
      chk_out("midreset", 1'b0, 32'h0, 4'h0, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      step();
      chk_out("postreset", 1'b0, 32'h0, 4'h0, 1'b1);

`ifdef EX_MEM_PERF_EN
      // Stall counter saturation, survives flush, cleared by reset.
      @(negedge clk);
      reset = 1'b1;
      step();
      @(negedge clk);
      reset = 1'b0;
      drive(1'b1, 32'h12345678, 4'h1, 1'b0, 1'b0);
      step();
      chk("perf.push", {28'd0, stall_cnt}, 32'd0);
      @(negedge clk);
      drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 5) chk("perf.cnt5", {28'd0, stall_cnt}, 32'd5);
         @(negedge clk);
      end
      chk("perf.sat", {28'd0, stall_cnt}, 32'd15);
      flush = 1'b1;
      step();
      chk("perf.flush", {28'd0, stall_cnt}, 32'd15);
      chk("perf.flush.mem_valid", {31'd0, mem_bus.valid}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      reset = 1'b1;
      step();
      chk("perf.reset", {28'd0, stall_cnt}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
